mac_requant_fifo: RTL and testbench
===================================

Name: mac_requant_fifo

Overview:
Downstream stage of the MAC unit. It captures each finished MAC result (16-bit sign-magnitude, 12 fraction bits) when the MAC's DONE rises. It requantizes the result to 8-bit sign-magnitude with 6 fraction bits, the same format as the MAC operands, using rounding and saturation. Results are buffered in a small FIFO and presented on a valid/ready interface to the next layer or the write-back logic.

Parameters:
IN_BITWIDTH, 16, width of IN_DATA (1 sign + 15 magnitude)
OUT_BITWIDTH, 8, width of OUT_DATA (1 sign + 7 magnitude)
SHIFT, 6, fraction-bit difference (12 - 6) removed by requantization
FIFO_DEPTH, 4, FIFO entries; power of 2, >= 2
CNT_BITWIDTH, 8, width of SAT_CNT

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
IN_VALID  input  1  connected to MAC DONE; level signal, may stay high for several cycles
IN_DATA  input  IN_BITWIDTH  MAC MOUT
OUT_VALID  output  1  FIFO non-empty
OUT_READY  input  1  consumer accepts head entry
OUT_DATA  output  OUT_BITWIDTH  head entry; 0 when empty
FULL  output  1  FIFO holds FIFO_DEPTH entries
OVERFLOW  output  1  sticky; a result was dropped
SAT_CNT  output  CNT_BITWIDTH  count of saturated results; saturates at all-ones

Behaviour:
- Reset: async, active-high. All FIFO pointers, count and stage-1 state clear. OUT_VALID=0, OUT_DATA=0, FULL=0, OVERFLOW=0, SAT_CNT=0, edge-detect register=0. Reset mid-operation discards all held and in-flight data.
- Capture: a new result is accepted only on a 0->1 transition of IN_VALID (registered previous value). Holding IN_VALID high produces exactly one capture. The edge-detect register resets to 0, so IN_VALID already high when RST deasserts counts as an edge on the first clock.
- Pipeline:
  - S0: edge seen at edge n; IN_DATA sampled into stage-1 register (s1_valid=1).
  - S1: requant computed combinationally from the stage-1 register; written to FIFO at edge n+1.
  - OUT_VALID rises after edge n+1 if the FIFO was empty. Latency 2 cycles.
  - Back-to-back edges are accepted every 2 cycles (0->1->0->1).
- Requant arithmetic:
  - mag_in = IN_DATA[14:0] (15 bits); sum = mag_in + 2^(SHIFT-1), computed at 16 bits; q = sum >> SHIFT.
  - Rounding is half-up on magnitude, i.e. round half away from zero.
  - If q > 127: magnitude = 127, and SAT_CNT increments (unless all-ones).
  - Sign = IN_DATA[15]. If the final magnitude is 0, sign is forced to 0 (no negative zero).
- FIFO:
  - Circular buffer with wrapping read/write pointers and an occupancy count of log2(FIFO_DEPTH)+1 bits.
  - Pop when OUT_VALID && OUT_READY; OUT_DATA then shows the next entry the following cycle.
  - Write when full with no simultaneous pop: the result is dropped, OVERFLOW is set (cleared only by RST), and the count is unchanged.
  - Full with a simultaneous pop: the write is accepted and the count stays at FIFO_DEPTH.
  - Empty with a simultaneous write: the new entry appears on OUT_DATA with OUT_VALID=1 the next cycle. There is no fall-through in the same cycle.
  - OUT_READY while empty: no effect.
- OUT_DATA, OUT_VALID and FULL are registered or derived only from registered state, with no combinational path from inputs.

Optional Feature:
Macro MAC_REQUANT_RELU_EN.
- Defined: after requantization, any result with sign=1 becomes 0x00 and does not count as saturated. SAT_CNT counts positive saturations only.
- Undefined: signed results pass through unchanged as specified above.

Test Plan:
- Basic rounding and sign (single-cycle IN_VALID pulse each):
  - IN_DATA=0x1000 -> OUT_DATA=0x40, OUT_VALID high 2 cycles after the edge.
  - IN_DATA=0x0020 -> 0x01 (half rounds up).
  - IN_DATA=0x001F -> 0x00.
  - IN_DATA=0x8040 -> 0x81.
  - IN_DATA=0x8010 -> 0x00 (negative zero normalized); with RELU_EN also 0x00.
- Saturation: IN_DATA=0x7FFF, then 0xFFFF -> 0x7F, 0xFF; SAT_CNT=2. With RELU_EN: 0x7F, 0x00; SAT_CNT=1.
- Level-held IN_VALID: hold high 5 cycles with IN_DATA=0x0080 -> exactly one entry 0x02; a second 0->1 edge -> a second entry.
- Full and overflow: OUT_READY=0, push 5 results 0x0040, 0x0080, 0x00C0, 0x0100, 0x0140 -> FULL=1 after the 4th, OVERFLOW=1 after the 5th. Draining yields 0x01, 0x02, 0x03, 0x04, then OUT_VALID=0 and OUT_DATA=0.
- Simultaneous pop and push at full: FIFO full, OUT_READY=1 in the cycle the 5th result writes -> no overflow, FULL stays 1, order preserved, wrap-around pointer verified.
- Reset mid-operation: assert RST one cycle after an edge with 2 entries queued -> all outputs 0 immediately (async). After release, OUT_VALID stays 0 until a new edge.

Source files
------------

// File: rtl/mac_requant_fifo.sv
// mac_requant_fifo: captures MAC results on the rising edge of IN_VALID,
// requantizes 16-bit sign-magnitude (12 frac bits) to 8-bit sign-magnitude
// (6 frac bits) with round-half-away-from-zero and saturation, and buffers
// the results in a small FIFO behind a valid/ready interface.
// Optional build macro: MAC_REQUANT_RELU_EN (negative results become 0x00,
// SAT_CNT then counts positive saturations only).
module mac_requant_fifo #(
    parameter int IN_BITWIDTH  = 16,
    parameter int OUT_BITWIDTH = 8,
    parameter int SHIFT        = 6,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_BITWIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VALID,
    input  logic [IN_BITWIDTH-1:0]  IN_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [OUT_BITWIDTH-1:0] OUT_DATA,
    output logic                    FULL,
    output logic                    OVERFLOW,
    output logic [CNT_BITWIDTH-1:0] SAT_CNT
);

    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int MAG_IN_W  = IN_BITWIDTH - 1;
    localparam int MAG_OUT_W = OUT_BITWIDTH - 1;
    localparam logic [IN_BITWIDTH-1:0] ROUND_ADD = {{(IN_BITWIDTH-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [IN_BITWIDTH-1:0] MAG_MAX   = {{(IN_BITWIDTH-MAG_OUT_W){1'b0}}, {MAG_OUT_W{1'b1}}};
    localparam logic [PTR_W:0]         DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic                    in_valid_q;
    logic                    s1_valid_q;
    logic [IN_BITWIDTH-1:0]  s1_data_q;
    logic [OUT_BITWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]          count_q;
    logic                    overflow_q;
    logic [CNT_BITWIDTH-1:0] sat_cnt_q;

    logic                    edge_d;
    logic [IN_BITWIDTH-1:0]  sum_d, quot_d;
    logic                    sat_d;
    logic [MAG_OUT_W-1:0]    mag_d;
    logic [OUT_BITWIDTH-1:0] rq_data_d;
    logic                    rq_sat_d;
    logic                    full_d, pop_d, wr_en_d, drop_d;

    assign edge_d = IN_VALID && !in_valid_q;

    // Requantize the stage-1 result: round magnitude half-up, saturate, fix sign.
    always_comb begin
        sum_d     = {1'b0, s1_data_q[MAG_IN_W-1:0]} + ROUND_ADD;
        quot_d    = sum_d >> SHIFT;
        sat_d     = quot_d > MAG_MAX;
        mag_d     = sat_d ? MAG_MAX[MAG_OUT_W-1:0] : quot_d[MAG_OUT_W-1:0];
`ifdef MAC_REQUANT_RELU_EN
        rq_data_d = s1_data_q[IN_BITWIDTH-1] ? '0 : {1'b0, mag_d};
        rq_sat_d  = sat_d && !s1_data_q[IN_BITWIDTH-1];
`else
        // A zero magnitude is always emitted as +0.
        rq_data_d = {s1_data_q[IN_BITWIDTH-1] && (mag_d != '0), mag_d};
        rq_sat_d  = sat_d;
`endif
    end

    // FIFO handshake decode; a push into a full FIFO survives only if a pop frees a slot.
    always_comb begin
        full_d  = (count_q == DEPTH_CNT);
        pop_d   = (count_q != '0) && OUT_READY;
        wr_en_d = s1_valid_q && (!full_d || pop_d);
        drop_d  = s1_valid_q && full_d && !pop_d;
    end

    // Edge detect on IN_VALID and stage-1 capture of the raw MAC result.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            in_valid_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            in_valid_q <= IN_VALID;
            s1_valid_q <= edge_d;
            if (edge_d) s1_data_q <= IN_DATA;
        end
    end

    // Circular buffer storage, wrapping pointers and occupancy count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_d) begin
                mem_q[wr_ptr_q] <= rq_data_d;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_d) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en_d, pop_d})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow flag and saturating count of clipped results.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overflow_q <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            if (drop_d) overflow_q <= 1'b1;
            if (s1_valid_q && rq_sat_d && (sat_cnt_q != '1)) sat_cnt_q <= sat_cnt_q + 1'b1;
        end
    end

    assign OUT_VALID = (count_q != '0);
    assign OUT_DATA  = OUT_VALID ? mem_q[rd_ptr_q] : '0;
    assign FULL      = full_d;
    assign OVERFLOW  = overflow_q;
    assign SAT_CNT   = sat_cnt_q;

endmodule

// File: tb/tb_mac_requant_fifo.sv
// Self-checking bench for mac_requant_fifo: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_mac_requant_fifo;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic [15:0] IN_DATA = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [7:0]  OUT_DATA;
    logic        FULL;
    logic        OVERFLOW;
    logic [7:0]  SAT_CNT;

    int checks = 0;
    int errors = 0;

    mac_requant_fifo dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .FULL(FULL), .OVERFLOW(OVERFLOW), .SAT_CNT(SAT_CNT)
    );

    always #5 CLK = ~CLK;

    // Reference requantization from plain integer arithmetic.
    function automatic logic [7:0] ref_rq(input logic [15:0] d, output bit sat);
        int m;
        int q;
        m   = int'(d[14:0]);
        q   = (m + 32) / 64;
        sat = (q > 127);
        if (sat) q = 127;
`ifdef MAC_REQUANT_RELU_EN
        if (d[15]) begin
            sat = 0;
            return 8'h00;
        end
`endif
        if (q == 0) return 8'h00;
        return {d[15], 7'(q)};
    endfunction

    task automatic do_reset();
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; IN_DATA = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Single-cycle IN_VALID pulse; returns after the FIFO write edge.
    task automatic push_pulse(input logic [15:0] d);
        @(negedge CLK); IN_VALID = 1'b1; IN_DATA = d;
        @(negedge CLK); IN_VALID = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", OUT_VALID); end
        checks++; if (OUT_DATA !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", OUT_DATA); end
        checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", FULL); end
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", OVERFLOW); end
        checks++; if (SAT_CNT !== 8'h00) begin errors++; $display("FAIL reset_sat got=%h exp=00", SAT_CNT); end
        // IN_VALID already high at reset release counts as an edge.
        RST = 1'b1; IN_VALID = 1'b1; IN_DATA = 16'h1000;
        @(negedge CLK); RST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h40) begin
            errors++; $display("FAIL reset_release_edge got=%b/%h exp=1/40", OUT_VALID, OUT_DATA); end
        IN_VALID = 1'b0;
        do_reset();
    endtask

    task automatic test_rounding();
        logic [15:0] din [5];
        logic [7:0]  dexp [5];
        din[0] = 16'h1000; dexp[0] = 8'h40;
        din[1] = 16'h0020; dexp[1] = 8'h01;
        din[2] = 16'h001F; dexp[2] = 8'h00;
`ifdef MAC_REQUANT_RELU_EN
        din[3] = 16'h8040; dexp[3] = 8'h00;
`else
        din[3] = 16'h8040; dexp[3] = 8'h81;
`endif
        din[4] = 16'h8010; dexp[4] = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK); IN_VALID = 1'b1; IN_DATA = din[i];
            @(negedge CLK);
            checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL round_latency[%0d] valid=%b exp=0", i, OUT_VALID); end
            IN_VALID = 1'b0;
            @(negedge CLK);
            checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== dexp[i]) begin
                errors++; $display("FAIL round[%0d] in=%h got=%b/%h exp=1/%h", i, din[i], OUT_VALID, OUT_DATA, dexp[i]); end
            OUT_READY = 1'b1;
            @(negedge CLK); OUT_READY = 1'b0;
            checks++; if (OUT_VALID !== 1'b0 || OUT_DATA !== 8'h00) begin
                errors++; $display("FAIL round_pop[%0d] got=%b/%h exp=0/00", i, OUT_VALID, OUT_DATA); end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] e2;
        logic [7:0] ecnt;
`ifdef MAC_REQUANT_RELU_EN
        e2 = 8'h00; ecnt = 8'd1;
`else
        e2 = 8'hFF; ecnt = 8'd2;
`endif
        do_reset();
        push_pulse(16'h7FFF);
        push_pulse(16'hFFFF);
        checks++; if (OUT_DATA !== 8'h7F) begin errors++; $display("FAIL sat_pos got=%h exp=7f", OUT_DATA); end
        OUT_READY = 1'b1;
        @(negedge CLK); OUT_READY = 1'b0;
        checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== e2) begin
            errors++; $display("FAIL sat_neg got=%b/%h exp=1/%h", OUT_VALID, OUT_DATA, e2); end
        checks++; if (SAT_CNT !== ecnt) begin errors++; $display("FAIL sat_cnt got=%0d exp=%0d", SAT_CNT, ecnt); end
        do_reset();
    endtask

    task automatic test_level_held();
        @(negedge CLK); IN_VALID = 1'b1; IN_DATA = 16'h0080;
        repeat (5) @(negedge CLK);
        IN_VALID = 1'b0;
        checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h02) begin
            errors++; $display("FAIL held_entry got=%b/%h exp=1/02", OUT_VALID, OUT_DATA); end
        OUT_READY = 1'b1;
        @(negedge CLK); OUT_READY = 1'b0;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL held_single got=%b exp=0", OUT_VALID); end
        push_pulse(16'h0080);
        checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h02) begin
            errors++; $display("FAIL held_second got=%b/%h exp=1/02", OUT_VALID, OUT_DATA); end
        OUT_READY = 1'b1;
        @(negedge CLK); OUT_READY = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_pulse(16'(16'h0040 * (i + 1)));
            if (i == 2) begin
                checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL ovf_notfull got=%b exp=0", FULL); end
            end
            if (i == 3) begin
                checks++; if (FULL !== 1'b1 || OVERFLOW !== 1'b0) begin
                    errors++; $display("FAIL ovf_full got=%b/%b exp=1/0", FULL, OVERFLOW); end
            end
        end
        checks++; if (FULL !== 1'b1 || OVERFLOW !== 1'b1) begin
            errors++; $display("FAIL ovf_set got=%b/%b exp=1/1", FULL, OVERFLOW); end
        for (int k = 1; k <= 4; k++) begin
            checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'(k)) begin
                errors++; $display("FAIL ovf_drain[%0d] got=%b/%h exp=1/%h", k, OUT_VALID, OUT_DATA, 8'(k)); end
            OUT_READY = 1'b1;
            @(negedge CLK); OUT_READY = 1'b0;
        end
        checks++; if (OUT_VALID !== 1'b0 || OUT_DATA !== 8'h00 || FULL !== 1'b0 || OVERFLOW !== 1'b1) begin
            errors++; $display("FAIL ovf_empty got=%b/%h/%b/%b exp=0/00/0/1", OUT_VALID, OUT_DATA, FULL, OVERFLOW); end
    endtask

    task automatic test_simul_push_pop();
        do_reset();
        for (int i = 1; i <= 4; i++) push_pulse(16'(16'h0040 * i));
        @(negedge CLK); IN_VALID = 1'b1; IN_DATA = 16'h0140;
        @(negedge CLK); IN_VALID = 1'b0; OUT_READY = 1'b1;
        @(negedge CLK); OUT_READY = 1'b0;
        checks++; if (FULL !== 1'b1 || OVERFLOW !== 1'b0 || OUT_DATA !== 8'h02) begin
            errors++; $display("FAIL simul got=%b/%b/%h exp=1/0/02", FULL, OVERFLOW, OUT_DATA); end
        for (int k = 2; k <= 5; k++) begin
            checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'(k)) begin
                errors++; $display("FAIL simul_drain[%0d] got=%b/%h exp=1/%h", k, OUT_VALID, OUT_DATA, 8'(k)); end
            OUT_READY = 1'b1;
            @(negedge CLK); OUT_READY = 1'b0;
        end
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL simul_empty got=%b exp=0", OUT_VALID); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_pulse(16'h0040);
        push_pulse(16'h0080);
        @(negedge CLK); IN_VALID = 1'b1; IN_DATA = 16'h00C0;
        @(negedge CLK); IN_VALID = 1'b0;
        RST = 1'b1;
        #1;
        checks++; if (OUT_VALID !== 1'b0 || OUT_DATA !== 8'h00 || FULL !== 1'b0 || OVERFLOW !== 1'b0 || SAT_CNT !== 8'h00) begin
            errors++; $display("FAIL rstmid_async got=%b/%h/%b/%b/%h exp=0/00/0/0/00", OUT_VALID, OUT_DATA, FULL, OVERFLOW, SAT_CNT); end
        @(negedge CLK); RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rstmid_idle[%0d] got=%b exp=0", i, OUT_VALID); end
        end
        push_pulse(16'h0040);
        checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h01) begin
            errors++; $display("FAIL rstmid_new got=%b/%h exp=1/01", OUT_VALID, OUT_DATA); end
        do_reset();
    endtask

    task automatic test_random();
        logic [7:0] mq[$];
        bit         pend = 0;
        logic [7:0] pval = '0;
        bit         psat = 0;
        bit         prev = 0;
        bit         movf = 0;
        int         msat = 0;
        bit         do_pop, was_full;
        logic [7:0] exp_data;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge CLK);
            exp_data = (mq.size() > 0) ? mq[0] : 8'h00;
            checks++; if (OUT_VALID !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, OUT_VALID, mq.size() > 0); end
            checks++; if (OUT_DATA !== exp_data) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, OUT_DATA, exp_data); end
            checks++; if (FULL !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", cyc, FULL, mq.size() == DEPTH); end
            checks++; if (OVERFLOW !== movf) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", cyc, OVERFLOW, movf); end
            checks++; if (SAT_CNT !== 8'(msat)) begin errors++; $display("FAIL rnd_sat cyc=%0d got=%0d exp=%0d", cyc, SAT_CNT, msat); end
            IN_VALID = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) IN_DATA = 16'($urandom);
            else IN_DATA = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 16'h2100))};
            if (cyc >= 300 && cyc < 400) OUT_READY = ($urandom_range(0, 7) == 0);
            else OUT_READY = ($urandom_range(0, 3) != 0);
            // Model the next rising edge.
            do_pop   = (mq.size() > 0) && OUT_READY;
            was_full = (mq.size() == DEPTH);
            if (do_pop) void'(mq.pop_front());
            if (pend) begin
                if (psat && msat < 255) msat++;
                if (!was_full || do_pop) mq.push_back(pval);
                else movf = 1;
            end
            pend = IN_VALID && !prev;
            if (pend) pval = ref_rq(IN_DATA, psat);
            prev = IN_VALID;
        end
        IN_VALID = 1'b0; OUT_READY = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_level_held();
        test_overflow();
        test_simul_push_pop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
